dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory target for the MIPS core's load/store path: the responder end of a valid/ready request–response memory interface.
- Accepts one word-sized read or write request, inserts a configurable number of wait states, performs the access, then holds the response until the initiator consumes it.
- Replaces the zero-latency data memory when the core moves to a stalling datapath.
- Owns its storage array. Flags misaligned and out-of-range accesses.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words in the array; must be a power of two.
- WAIT_CYCLES, 2: wait states between accept and access; legal range 0..15.
- ADDR_W, 32: request byte-address width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables; bit i covers wdata[8i+7:8i].
- resp_valid  out  1  response available.
- resp_ready  in  1  initiator consumes the response.
- resp_rdata  out  32  load data; 0 for stores and for errors.
- resp_err  out  1  access was misaligned or out of range.

Behaviour:
- Reset (async): state=IDLE, cnt=0, resp_valid=0, resp_rdata=0, resp_err=0. req_ready=1 once reset deasserts.
- Reset does not clear the array.
- States and transitions:
  - IDLE: req_ready=1. On an edge with req_valid=1, latch addr, write, wdata and be; load cnt=WAIT_CYCLES; go to WAIT.
  - WAIT: req_ready=0. If cnt!=0, decrement cnt. If cnt==0, perform the access at this edge, register rdata and err, and go to RESP.
  - RESP: resp_valid=1. resp_rdata and resp_err stay stable while resp_ready=0. On an edge with resp_ready=1, go to IDLE and drop resp_valid.
- Latency: request accepted at edge E0 produces resp_valid high after edge E0+WAIT_CYCLES+1.
  - WAIT_CYCLES=0 gives one WAIT cycle.
- No acceptance in the same cycle as the response handshake. Minimum spacing between accepts is WAIT_CYCLES+3 edges.
- Word index = addr[ADDR_W-1:2]. Indices are never wrapped.
- Error if addr[1:0]!=0 or index>=DEPTH_WORDS:
  - no array write;
  - rdata=0, err=1.
  - The error response still follows full latency and the handshake.
- Store: each byte with be[i]=1 is written. be=4'b0000 is a legal no-op with err=0. rdata=0.
- Load: rdata is the full word; be is ignored.
- Request inputs are sampled only at the accept edge. Later changes on them have no effect on the transaction in flight.
- Reset during WAIT: transaction abandoned, no array write.
- Reset during RESP: response dropped; array keeps any completed write.
- resp_ready while not in RESP is ignored.

Decomposition:
- Package dmem_pkg holds:
  - state encoding (IDLE, WAIT, RESP);
  - WORD_W=32, BE_W=4, CNT_W=4;
  - an alignment-check helper.
- One sub-module, dmem_array:
  - synchronous byte-enabled write port and registered read port;
  - enable-gated by the FSM;
  - no reset on storage.

Test Plan:
- Store then load, WAIT_CYCLES=2: store addr 0x10, wdata 0xDEADBEEF, be=4'hF, then load 0x10 -> rdata=0xDEADBEEF, err=0, resp_valid exactly 3 edges after each accept.
- Partial write: store 0x10 with wdata 0x000000AA, be=4'b0001 over 0xDEADBEEF, then load -> 0xDEADBEAA.
- Misaligned address: load 0x12 -> err=1, rdata=0. Store 0x13 -> err=1, and a subsequent load of 0x10 is unchanged.
- Out of range with DEPTH_WORDS=256: store 0x400 -> err=1, no write. Load 0x3FC -> err=0.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid, rdata and err stable, req_ready=0. Raise resp_ready -> IDLE next edge, req_ready=1.
- Reset mid-WAIT: accept store 0x20 of 0x12345678, pulse reset at cnt=1 -> outputs cleared, a later load of 0x20 returns the prior contents. WAIT_CYCLES=0 build: latency is 1 edge.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths, FSM state encoding and alignment helper for the data-memory responder
package dmem_pkg;
  localparam int WORD_W = 32;
  localparam int BE_W = 4;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  function automatic logic is_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction
endpackage

// File: rtl/dmem_if.sv
// dmem_if: valid/ready request-response bus between the core's load/store path and data memory
interface dmem_if #(parameter int ADDR_W = 32);
  import dmem_pkg::*;
  logic req_valid;
  logic req_ready;
  logic req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic [BE_W-1:0] req_be;
  logic resp_valid;
  logic resp_ready;
  logic [WORD_W-1:0] resp_rdata;
  logic resp_err;
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    input req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_array.sv
// dmem_array: word storage with byte-enabled synchronous write and registered read, no storage reset
module dmem_array import dmem_pkg::*; #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [AW-1:0]     idx_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);
  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      for (int b = 0; b < BE_W; b++)
        if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
    if (en_i && !we_i) rdata_q <= mem_q[idx_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated data-memory target; accepts one request, waits, accesses, holds response
module dmem_responder import dmem_pkg::*; #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W = 32
) (
  input logic clk,
  input logic reset,
  dmem_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic write_q, err_q, access, bad;
  logic [WORD_W-1:0] wdata_q, rdata;
  logic [BE_W-1:0] be_q;
  // any address bit above the array's index range means out of range; indices never wrap
  assign bad = !is_aligned(addr_q[1:0]) || ((addr_q >> (AW + 2)) != '0);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    access = 1'b0;
    unique case (state_q)
      IDLE: if (bus.req_valid) begin
        state_d = WAIT;
        cnt_d = CNT_W'(WAIT_CYCLES);
      end
      WAIT: if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      else begin
        access = 1'b1;
        state_d = RESP;
      end
      RESP: if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      err_q <= 1'b0;
      addr_q <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      be_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (state_q == IDLE && bus.req_valid) begin
        addr_q <= bus.req_addr;
        write_q <= bus.req_write;
        wdata_q <= bus.req_wdata;
        be_q <= bus.req_be;
      end
      if (access) err_q <= bad;
    end
  end
  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk     (clk),
    .en_i    (access && !bad),
    .we_i    (write_q),
    .be_i    (be_q),
    .idx_i   (addr_q[AW+1:2]),
    .wdata_i (wdata_q),
    .rdata_o (rdata)
  );
  assign bus.req_ready = state_q == IDLE;
  assign bus.resp_valid = state_q == RESP;
  assign bus.resp_err = bus.resp_valid && err_q;
  // read register is only meaningful for a successful load in RESP
  assign bus.resp_rdata = (bus.resp_valid && !err_q && !write_q) ? rdata : '0;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of dmem_responder against a word-array model
module tb_dmem_responder;
  import dmem_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic sel = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0] req_be = '0;
  logic req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  dmem_if #(.ADDR_W(32)) bus_a ();
  dmem_if #(.ADDR_W(32)) bus_b ();
  assign bus_a.req_valid = req_valid && !sel;
  assign bus_b.req_valid = req_valid && sel;
  assign bus_a.resp_ready = resp_ready && !sel;
  assign bus_b.resp_ready = resp_ready && sel;
  assign bus_a.req_write = req_write;
  assign bus_b.req_write = req_write;
  assign bus_a.req_addr = req_addr;
  assign bus_b.req_addr = req_addr;
  assign bus_a.req_wdata = req_wdata;
  assign bus_b.req_wdata = req_wdata;
  assign bus_a.req_be = req_be;
  assign bus_b.req_be = req_be;
  assign req_ready = sel ? bus_b.req_ready : bus_a.req_ready;
  assign resp_valid = sel ? bus_b.resp_valid : bus_a.resp_valid;
  assign resp_err = sel ? bus_b.resp_err : bus_a.resp_err;
  assign resp_rdata = sel ? bus_b.resp_rdata : bus_a.resp_rdata;
  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .ADDR_W(32)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .ADDR_W(32)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));
  int checks = 0;
  int errors = 0;
  logic [31:0] model [256];
  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction
  function automatic void model_access(input logic w, input logic [31:0] a, input logic [31:0] wd,
                                       input logic [3:0] be, output logic [31:0] rd,
                                       output logic e);
    int idx;
    idx = int'(a >> 2);
    e = (a[1:0] != 2'b00) || (a >= 32'd1024);
    rd = '0;
    if (!e && w) model[idx] = merge(model[idx], wd, be);
    else if (!e) rd = model[idx];
  endfunction
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr = a;
    req_wdata = wd;
    req_be = be;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr = $urandom;
    req_wdata = $urandom;
    req_be = 4'($urandom);
  endtask
  task automatic wait_resp(output int lat);
    lat = 1;
    @(posedge clk);
    #1;
    while (!resp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask
  task automatic consume();
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, output logic [31:0] rd, output logic e, output int lat);
    issue(w, a, wd, be);
    wait_resp(lat);
    rd = resp_rdata;
    e = resp_err;
    consume();
  endtask
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs valid=%b rdata=%h err=%b required 0/0/0", resp_valid, resp_rdata, resp_err);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got=%b required 1", req_ready);
    end
  endtask
  task automatic test_store_load();
    logic [31:0] rd, er_rd;
    logic e, er;
    int lat;
    model_access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, er_rd, er);
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e, lat);
    checks++;
    if (rd !== 32'h0 || e !== 1'b0 || lat !== 3) begin
      errors++;
      $display("FAIL store_full rdata=%h err=%b lat=%0d required 0/0/3", rd, e, lat);
    end
    model_access(1'b0, 32'h10, 32'h0, 4'h0, er_rd, er);
    txn(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
    checks++;
    if (rd !== 32'hDEADBEEF || rd !== er_rd || e !== 1'b0 || lat !== 3) begin
      errors++;
      $display("FAIL load_full rdata=%h err=%b lat=%0d required deadbeef/0/3", rd, e, lat);
    end
  endtask
  task automatic test_partial();
    logic [31:0] rd, er_rd;
    logic e, er;
    int lat;
    model_access(1'b1, 32'h10, 32'h000000AA, 4'b0001, er_rd, er);
    txn(1'b1, 32'h10, 32'h000000AA, 4'b0001, rd, e, lat);
    txn(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
    checks++;
    if (rd !== 32'hDEADBEAA || e !== 1'b0) begin
      errors++;
      $display("FAIL partial_write rdata=%h err=%b required deadbeaa/0", rd, e);
    end
  endtask
  task automatic test_misaligned();
    logic [31:0] rd;
    logic e;
    int lat;
    txn(1'b0, 32'h12, 32'h0, 4'hF, rd, e, lat);
    checks++;
    if (rd !== 32'h0 || e !== 1'b1 || lat !== 3) begin
      errors++;
      $display("FAIL misaligned_load rdata=%h err=%b lat=%0d required 0/1/3", rd, e, lat);
    end
    txn(1'b1, 32'h13, 32'h55667788, 4'hF, rd, e, lat);
    checks++;
    if (rd !== 32'h0 || e !== 1'b1) begin
      errors++;
      $display("FAIL misaligned_store rdata=%h err=%b required 0/1", rd, e);
    end
    txn(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
    checks++;
    if (rd !== 32'hDEADBEAA || e !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_nowrite rdata=%h err=%b required deadbeaa/0", rd, e);
    end
  endtask
  task automatic test_range();
    logic [31:0] rd, er_rd;
    logic e, er;
    int lat;
    model_access(1'b1, 32'h0, 32'h0BADF00D, 4'hF, er_rd, er);
    txn(1'b1, 32'h0, 32'h0BADF00D, 4'hF, rd, e, lat);
    model_access(1'b1, 32'h3FC, 32'hA5A55A5A, 4'hF, er_rd, er);
    txn(1'b1, 32'h3FC, 32'hA5A55A5A, 4'hF, rd, e, lat);
    txn(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, rd, e, lat);
    checks++;
    if (rd !== 32'h0 || e !== 1'b1 || lat !== 3) begin
      errors++;
      $display("FAIL range_store rdata=%h err=%b lat=%0d required 0/1/3", rd, e, lat);
    end
    txn(1'b0, 32'h0, 32'h0, 4'h0, rd, e, lat);
    checks++;
    if (rd !== 32'h0BADF00D || e !== 1'b0) begin
      errors++;
      $display("FAIL range_nowrap rdata=%h err=%b required 0badf00d/0", rd, e);
    end
    txn(1'b0, 32'h3FC, 32'h0, 4'h0, rd, e, lat);
    checks++;
    if (rd !== 32'hA5A55A5A || e !== 1'b0) begin
      errors++;
      $display("FAIL range_top rdata=%h err=%b required a5a55a5a/0", rd, e);
    end
  endtask
  task automatic test_backpressure();
    logic [31:0] rd;
    logic e;
    int lat;
    issue(1'b0, 32'h3FC, 32'h0, 4'h0);
    wait_resp(lat);
    rd = resp_rdata;
    e = resp_err;
    checks++;
    if (rd !== 32'hA5A55A5A || e !== 1'b0 || lat !== 3) begin
      errors++;
      $display("FAIL bp_first rdata=%h err=%b lat=%0d required a5a55a5a/0/3", rd, e, lat);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'hA5A55A5A || resp_err !== 1'b0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle=%0d valid=%b rdata=%h err=%b ready=%b required 1/a5a55a5a/0/0",
                 i, resp_valid, resp_rdata, resp_err, req_ready);
      end
    end
    consume();
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release ready=%b valid=%b required 1/0", req_ready, resp_valid);
    end
  endtask
  task automatic test_reset_wait();
    logic [31:0] rd, er_rd;
    logic e, er;
    int lat;
    model_access(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, er_rd, er);
    txn(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, rd, e, lat);
    issue(1'b1, 32'h20, 32'h12345678, 4'hF);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_wait_outputs valid=%b rdata=%h err=%b ready=%b required 0/0/0/1",
               resp_valid, resp_rdata, resp_err, req_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    txn(1'b0, 32'h20, 32'h0, 4'h0, rd, e, lat);
    checks++;
    if (rd !== 32'hCAFEF00D || e !== 1'b0) begin
      errors++;
      $display("FAIL reset_wait_nowrite rdata=%h err=%b required cafef00d/0", rd, e);
    end
  endtask
  task automatic test_zero_wait();
    logic [31:0] rd;
    logic e;
    int lat;
    sel = 1'b1;
    txn(1'b1, 32'h8, 32'h13579BDF, 4'hF, rd, e, lat);
    checks++;
    if (e !== 1'b0 || lat !== 1) begin
      errors++;
      $display("FAIL zero_wait_store err=%b lat=%0d required 0/1", e, lat);
    end
    txn(1'b0, 32'h8, 32'h0, 4'h0, rd, e, lat);
    checks++;
    if (rd !== 32'h13579BDF || e !== 1'b0 || lat !== 1) begin
      errors++;
      $display("FAIL zero_wait_load rdata=%h err=%b lat=%0d required 13579bdf/0/1", rd, e, lat);
    end
    sel = 1'b0;
  endtask
  task automatic test_random();
    logic [31:0] rd, er_rd, a, wd;
    logic e, er, w;
    logic [3:0] be;
    int lat, r;
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      model_access(1'b1, 32'(i * 4), wd, 4'hF, er_rd, er);
      txn(1'b1, 32'(i * 4), wd, 4'hF, rd, e, lat);
    end
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      a = r < 7 ? 32'($urandom_range(0, 15) * 4) :
          r == 7 ? 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3)) :
          r == 8 ? 32'h400 + 32'($urandom_range(0, 255) * 4) : ($urandom | 32'h400);
      w = 1'($urandom);
      wd = $urandom;
      be = 4'($urandom);
      model_access(w, a, wd, be, er_rd, er);
      txn(w, a, wd, be, rd, e, lat);
      checks++;
      if (rd !== er_rd || e !== er || lat !== 3) begin
        errors++;
        $display("FAIL random #%0d w=%b addr=%h be=%h rdata=%h err=%b lat=%0d required %h/%b/3",
                 i, w, a, be, rd, e, lat, er_rd, er);
      end
    end
  endtask
  initial begin
    test_reset();
    test_store_load();
    test_partial();
    test_misaligned();
    test_range();
    test_backpressure();
    test_reset_wait();
    test_zero_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
